m_pcpi_frontend: RTL and testbench

- Upstream issue/response stage between the core's PCPI bus and the M-unit controller.
- Decodes M-extension instructions and latches the instruction and operands.
- Holds them stable for the unit for the whole operation, since the unit reads rs1/rs2 again in its final cycle.
- Captures the unit result, returns it to the core with a one-cycle ready, and adds timeout, abort and completion-count handling.

---
 rtl/m_pcpi_frontend.sv | 148 ++++++++++++++
 tb/tb_m_pcpi_frontend.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_pcpi_frontend.sv
// PCPI issue/response front end for the M-unit: decode, operand hold, result return,
// timeout, abort and completion counting. Accept-to-ready latency is 3 + unit latency.
module m_pcpi_frontend #(
  parameter logic [6:0] OPCODE         = 7'b0110011,
  parameter logic [6:0] FUNC7          = 7'b0000001,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pcpi_valid,
  input  logic [31:0]      pcpi_insn,
  input  logic [31:0]      pcpi_rs1,
  input  logic [31:0]      pcpi_rs2,
  output logic             pcpi_wait,
  output logic             pcpi_ready,
  output logic             pcpi_wr,
  output logic [31:0]      pcpi_rd,
  output logic             m_valid,
  output logic [31:0]      m_insn,
  output logic [31:0]      m_rs1,
  output logic [31:0]      m_rs2,
  input  logic             m_ready,
  input  logic             m_wr,
  input  logic [31:0]      m_rd,
  input  logic             m_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_COOL} state_t;

  state_t           state_q, state_d;
  logic [31:0]      insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]      result_q, result_d;
  logic             wr_q, wr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             abort_q, abort_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic match, accept, timer_done;

  assign match      = (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNC7);
  assign accept     = pcpi_valid && match && !m_busy;
  assign timer_done = (timer_q == TMAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      insn_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      wr_q     <= 1'b0;
      timer_q  <= '0;
      abort_q  <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      insn_q   <= insn_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      wr_q     <= wr_d;
      timer_q  <= timer_d;
      abort_q  <= abort_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // A withdrawal seen in the same cycle as m_ready already counts as an abort.
  always_comb begin
    insn_d   = insn_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    result_d = result_q;
    wr_d     = wr_q;
    timer_d  = timer_q;
    abort_d  = abort_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          insn_d  = pcpi_insn;
          rs1_d   = pcpi_rs1;
          rs2_d   = pcpi_rs2;
          timer_d = '0;
          abort_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + 1'b1;
        abort_d = abort_q || !pcpi_valid;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        abort_d = abort_q || !pcpi_valid;
        if (m_ready) begin
          result_d = m_rd;
          wr_d     = m_wr;
        end else if (timer_done) begin
          result_d = '0;
          wr_d     = 1'b0;
          tmo_d    = 1'b1;
        end
      end
      S_RESP: begin
        if (!tmo_q) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (m_ready || timer_done) state_d = abort_d ? S_COOL : S_RESP;
      S_RESP:  state_d = S_COOL;
      S_COOL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_valid     = (state_q == S_ISSUE);
    pcpi_wait   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !abort_q;
    pcpi_ready  = (state_q == S_RESP);
    pcpi_wr     = (state_q == S_RESP) && wr_q;
    pcpi_rd     = (state_q == S_RESP) ? result_q : 32'd0;
    timeout_err = (state_q == S_RESP) && tmo_q;
  end

  assign m_insn   = insn_q;
  assign m_rs1    = rs1_q;
  assign m_rs2    = rs2_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// Directed bench for m_pcpi_frontend with a latency-programmable M-unit stub.
module tb_m_pcpi_frontend;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wait, pcpi_ready, pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        m_valid;
  logic [31:0] m_insn, m_rs1, m_rs2;
  logic        m_ready, m_wr, m_busy;
  logic [31:0] m_rd;
  logic        timeout_err;
  logic [15:0] op_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n;
  int          stub_lat = 2;
  int          stub_cnt = 0;
  logic        stub_hang = 1'b0;
  logic [31:0] stub_res = '0;

  localparam logic [31:0] I_MUL   = 32'h02B50533;
  localparam logic [31:0] I_MULHU = 32'h02C5B533;
  localparam logic [31:0] I_DIVU  = 32'h02C5D533;
  localparam logic [31:0] I_DIV   = 32'h02C5C533;
  localparam logic [31:0] I_ADD   = 32'h00B50533;

  m_pcpi_frontend #(
    .OPCODE(7'b0110011), .FUNC7(7'b0000001), .TIMEOUT_CYCLES(64), .CNT_W(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .m_valid(m_valid), .m_insn(m_insn), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_ready(m_ready), .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy),
    .timeout_err(timeout_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Unit stub: m_ready comes stub_lat+1 negedges after m_valid is seen, unless hung.
  assign m_busy = stub_hang || (stub_cnt != 0);
  initial begin
    m_ready = 1'b0;
    m_rd    = '0;
    m_wr    = 1'b0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      m_rd    = stub_res;
      m_wr    = 1'b1;
      if (stub_cnt > 0) begin
        stub_cnt = stub_cnt - 1;
        if (stub_cnt == 0 && !stub_hang) m_ready = 1'b1;
      end
      if (m_valid) stub_cnt = stub_lat + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    pcpi_valid = 1'b1;
    pcpi_insn  = i;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
  endtask

  task automatic wait_ready(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!pcpi_ready && cnt < budget);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn = '0;
    pcpi_rs1 = '0;
    pcpi_rs2 = '0;
    #12;
    check("rst_ctrl", {pcpi_wait, pcpi_ready, pcpi_wr, m_valid, timeout_err, op_count}, '0);
    check("rst_data", {pcpi_rd, m_insn, m_rs1, m_rs2}, '0);
    tick();
    resetn = 1'b1;
    tick();

    // MUL, then back-to-back MULHU with pcpi_valid held through ready and COOL
    stub_lat = 2; stub_res = 42;
    req(I_MUL, 32'd7, 32'd6);
    tick();
    check("mul_issue", {m_valid, pcpi_wait}, 2'b11);
    check("mul_ops", {m_insn, m_rs1, m_rs2}, {I_MUL, 32'd7, 32'd6});
    tick();
    check("mul_mvalid_1cyc", {m_valid, pcpi_wait}, 2'b01);
    tick();
    tick();
    check("mul_not_early", pcpi_ready, 1'b0);
    tick();
    check("mul_resp", {pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}, {3'b110, 32'd42});
    stub_res = 32'd2;
    req(I_MULHU, 32'h8000_0000, 32'd4);
    tick();
    check("b2b_cool", {m_valid, pcpi_wait, pcpi_ready, op_count}, {3'b000, 16'd1});
    tick();
    check("b2b_idle", {m_valid, pcpi_wait}, 2'b00);
    tick();
    check("b2b_issue", {m_valid, m_insn, m_rs1}, {1'b1, I_MULHU, 32'h8000_0000});
    wait_ready(20, n);
    check("b2b_lat", n, 4);
    check("b2b_resp", {pcpi_wr, pcpi_rd}, {1'b1, 32'd2});
    pcpi_valid = 1'b0;
    tick();
    check("b2b_cnt", op_count, 16'd2);

    // DIVU through a 34-cycle unit: operands held, single-cycle ready
    tick();
    stub_lat = 34; stub_res = 14;
    req(I_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 36; k++) begin
      tick();
      check("div_hold", {pcpi_wait, pcpi_ready, m_rs1, m_rs2}, {2'b10, 32'd100, 32'd7});
    end
    tick();
    check("div_resp", {pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}, {3'b110, 32'd14});
    pcpi_valid = 1'b0;
    tick();
    check("div_single", {pcpi_ready, op_count}, {1'b0, 16'd3});

    // ADD is not an M instruction and must be ignored completely
    tick();
    req(I_ADD, 32'd1, 32'd2);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("add_ignored", {m_valid, pcpi_wait, pcpi_ready}, 3'b000);
    end
    pcpi_valid = 1'b0;

    // Timeout: unit never answers and stays busy afterwards
    tick();
    stub_lat = 2;
    req(I_DIV, 32'd9, 32'd3);
    tick();
    stub_hang = 1'b1;
    stub_res  = 32'hDEAD;
    wait_ready(100, n);
    check("tmo_lat", n, 64);
    check("tmo_resp", {pcpi_ready, pcpi_wr, timeout_err, pcpi_rd}, {3'b101, 32'd0});
    pcpi_valid = 1'b0;
    tick();
    check("tmo_pulse", {timeout_err, op_count}, {1'b0, 16'd3});
    req(I_MUL, 32'd5, 32'd5);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("tmo_holdoff", {m_valid, pcpi_wait}, 2'b00);
    end
    stub_hang = 1'b0;
    stub_res  = 32'd25;
    wait_ready(20, n);
    check("tmo_next_lat", n, 5);
    check("tmo_next_rd", {pcpi_wr, pcpi_rd}, {1'b1, 32'd25});
    pcpi_valid = 1'b0;
    tick();
    check("tmo_next_cnt", op_count, 16'd4);

    // Abort: core withdraws 3 cycles into a DIV
    tick();
    stub_lat = 34; stub_res = 32'd77;
    req(I_DIV, 32'd50, 32'd5);
    tick();
    tick();
    tick();
    check("abt_wait_pre", pcpi_wait, 1'b1);
    pcpi_valid = 1'b0;
    tick();
    check("abt_wait_drop", {pcpi_wait, m_valid}, 2'b00);
    for (int k = 0; k < 36; k++) begin
      tick();
      check("abt_no_ready", {pcpi_ready, pcpi_wait, timeout_err}, 3'b000);
    end
    check("abt_cnt", op_count, 16'd4);

    // Reset in the middle of WAIT
    tick();
    req(I_DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    check("rst_pre_wait", pcpi_wait, 1'b1);
    resetn = 1'b0;
    pcpi_valid = 1'b0;
    #1;
    check("rst_mid_ctrl", {pcpi_wait, pcpi_ready, pcpi_wr, m_valid, timeout_err, op_count}, '0);
    check("rst_mid_data", {pcpi_rd, m_insn, m_rs1, m_rs2}, '0);
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("rst_no_ready", {pcpi_ready, m_valid, pcpi_wait}, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
